// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: state encoding,
// instruction length field location and the length decode helper.
package fetch_pkg;

  localparam int BYTE_W          = 8;
  localparam int LEN_FIELD_MSB   = 7;
  localparam int LEN_FIELD_LSB   = 6;
  localparam int MAX_INSTR_BYTES = 3;

  typedef enum logic [2:0] {
    S_CLEAR,
    S_REQ,
    S_PUSH,
    S_WAIT,
    S_ERR
  } state_t;

  // Length field 0..3 maps to 1..3 bytes; field value 3 saturates to 3.
  function automatic logic [1:0] instr_len(input logic [BYTE_W-1:0] byte0);
    logic [2:0] raw;
    raw = {1'b0, byte0[LEN_FIELD_MSB:LEN_FIELD_LSB]} + 3'd1;
    if (raw > 3'(MAX_INSTR_BYTES)) begin
      raw = 3'(MAX_INSTR_BYTES);
    end
    return raw[1:0];
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Cycle counter that flags expiry on the LIMIT-th consecutive enabled cycle.
// Used by instruction_fetch only when FETCH_TIMEOUT_EN is defined.
module fetch_watchdog #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expired = en && (cnt_q == CNT_W'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetches 1-3 byte instructions over a req/ack byte memory and streams them
// into the instruction register. Define FETCH_TIMEOUT_EN for the ack watchdog.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter int                TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              ir_clr,
  output logic              ir_en,
  output logic [7:0]        ir_wrd,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              fetch_err
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [1:0]        len_q, len_d;
  logic [7:0]        ir_wrd_q, ir_wrd_d;
  logic              mem_req_q, mem_req_d;
  logic              ir_en_q, ir_en_d;
  logic              instr_valid_q, instr_valid_d;
  logic              fetch_err_q, fetch_err_d;

`ifdef FETCH_TIMEOUT_EN
  logic wd_expired;

  fetch_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != S_REQ),
    .en      (state_q == S_REQ),
    .expired (wd_expired)
  );
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    ir_wrd_d    = ir_wrd_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      S_CLEAR: begin
        byte_cnt_d = '0;
        state_d    = S_REQ;
      end
      S_REQ: begin
        // An ack in the expiry cycle still wins over the timeout.
        if (mem_ack) begin
          ir_wrd_d   = mem_rdata;
          pc_d       = pc_q + 1'b1;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd0) begin
            len_d = instr_len(mem_rdata);
          end
          state_d = S_PUSH;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (wd_expired) begin
          fetch_err_d = 1'b1;
          state_d     = S_ERR;
        end
`endif
      end
      S_PUSH: begin
        state_d = (byte_cnt_q == len_q) ? S_WAIT : S_REQ;
      end
      S_WAIT: begin
        if (exec_done) begin
          if (jump_en) begin
            pc_d = jump_addr;
          end
          state_d = S_CLEAR;
        end
      end
`ifdef FETCH_TIMEOUT_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      default: begin
        state_d = S_CLEAR;
      end
    endcase

    mem_req_d     = (state_d == S_REQ);
    ir_en_d       = (state_d == S_PUSH);
    instr_valid_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_CLEAR;
      pc_q          <= RESET_PC;
      byte_cnt_q    <= '0;
      len_q         <= '0;
      ir_wrd_q      <= '0;
      mem_req_q     <= 1'b0;
      ir_en_q       <= 1'b0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      byte_cnt_q    <= byte_cnt_d;
      len_q         <= len_d;
      ir_wrd_q      <= ir_wrd_d;
      mem_req_q     <= mem_req_d;
      ir_en_q       <= ir_en_d;
      instr_valid_q <= instr_valid_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign ir_clr      = (state_q == S_CLEAR);
  assign mem_req     = mem_req_q;
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign ir_en       = ir_en_q;
  assign ir_wrd      = ir_wrd_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule
